// File: rtl/wb_int_ctrl.sv
// Wishbone interrupt controller: synchronises, latches (level/edge), masks and prioritises N_SRC sources.
// Define INTC_SYNC_EN for the 2-flop input synchroniser; leave it undefined for sources already in the clk domain.
module wb_int_ctrl #(
   parameter int          N_SRC      = 6,
   parameter logic [31:0] RESET_MASK = 32'h0,
   parameter logic [31:0] RESET_MODE = 32'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             STB,
   input  logic             WE,
   input  logic [2:0]       ADDR,
   input  logic [31:0]      DAT_I,
   output logic [31:0]      DAT_O,
   output logic             ACK,
   input  logic [N_SRC-1:0] irq_src,
   output logic             INT,
   output logic [31:0]      CAUSE
);

   // Handshake: a transfer is committed on the first edge that sees STB=1 in IDLE.
   // ACK then stays high until STB drops, so a slow master sees exactly one side effect.
   typedef enum logic {IDLE = 1'b0, ACKD = 1'b1} bus_state_t;

   bus_state_t       state, state_nxt;
   logic             commit;
   logic [N_SRC-1:0] s2, s3, evt;
   logic [N_SRC-1:0] pend, mask, mode, pend_nxt;
   logic [N_SRC-1:0] active, lowest, clr, to_edge;
   logic             wr_pend, wr_mask, wr_mode, claim;
   logic [31:0]      rdata, pend_w, mask_w, mode_w;
   logic             unused_dat;

   assign unused_dat = ^DAT_I;

`ifdef INTC_SYNC_EN
   logic [N_SRC-1:0] s1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= irq_src;
         s2 <= s1;
         s3 <= s2;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2 <= '0;
         s3 <= '0;
      end else begin
         s2 <= irq_src;
         s3 <= s2;
      end
   end
`endif

   assign evt = s2 & ~s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ACK       = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (STB) begin
               commit    = 1'b1;
               state_nxt = ACKD;
            end
         end
         ACKD: begin
            ACK = 1'b1;
            if (!STB) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wr_pend = commit &  WE & (ADDR == 3'd0);
   assign wr_mask = commit &  WE & (ADDR == 3'd1);
   assign wr_mode = commit &  WE & (ADDR == 3'd2);
   assign claim   = commit & ~WE & (ADDR == 3'd3);

   assign active = pend & mask;
   assign INT    = |active;

   // Descending scan so the lowest active index is the last one assigned.
   always_comb begin
      CAUSE  = 32'd0;
      lowest = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            CAUSE     = 32'(i);
            lowest    = '0;
            lowest[i] = 1'b1;
         end
      end
   end

   // Only edge-mode bits are clearable; a fresh event in the same cycle wins over the clear.
   always_comb begin
      clr      = mode & ((wr_pend ? DAT_I[N_SRC-1:0] : '0) | (claim ? lowest : '0));
      to_edge  = wr_mode ? (DAT_I[N_SRC-1:0] & ~mode) : '0;
      pend_nxt = (mode & ((pend & ~clr) | evt)) | (~mode & s2);
      pend_nxt = pend_nxt & ~to_edge;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
         mask <= RESET_MASK[N_SRC-1:0];
         mode <= RESET_MODE[N_SRC-1:0];
      end else begin
         pend <= pend_nxt;
         if (wr_mask) mask <= DAT_I[N_SRC-1:0];
         if (wr_mode) mode <= DAT_I[N_SRC-1:0];
      end
   end

   always_comb begin
      pend_w = '0;
      mask_w = '0;
      mode_w = '0;
      pend_w[N_SRC-1:0] = pend;
      mask_w[N_SRC-1:0] = mask;
      mode_w[N_SRC-1:0] = mode;
      case (ADDR)
         3'd0:    rdata = pend_w;
         3'd1:    rdata = mask_w;
         3'd2:    rdata = mode_w;
         3'd3:    rdata = INT ? CAUSE : 32'hFFFF_FFFF;
         3'd4:    rdata = {16'h1C0A, 8'd0, 8'(N_SRC)};
         default: rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         DAT_O <= 32'd0;
      else if (commit) DAT_O <= rdata;
   end

endmodule
